edge_detection_axil_regs: RTL and testbench

AXI4-Lite slave register file for the edge-detection IP, sitting on the S00_AXI port. It is the responder end of the AXI4-Lite master/VIP traffic that configures the core. It holds four 32-bit read/write registers with byte strobes and drives their contents to the edge-detection datapath. It also emits a one-cycle write-strobe per register so the core can react to updates.

---
 rtl/edge_detection_pkg.sv | 26 ++
 rtl/edge_detection_axil_regs_if.sv | 39 +++
 rtl/edge_detection_axil_wstrb_merge.sv | 19 +
 rtl/edge_detection_axil_regs.sv | 167 ++++++++++++++++
 tb/tb_edge_detection_axil_regs.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_detection_pkg.sv
// Shared constants and FSM state types for the edge-detection AXI4-Lite register block.
package edge_detection_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_THRESH = 2'd1;
  localparam logic [1:0] REG_WIDTH  = 2'd2;
  localparam logic [1:0] REG_HEIGHT = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/edge_detection_axil_regs_if.sv
// AXI4-Lite bus bundle between the configuring master and the register slave.
interface edge_detection_axil_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/edge_detection_axil_wstrb_merge.sv
// Byte-lane merge: each byte comes from new_data where its strobe is set, else from old_data.
module edge_detection_axil_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    // NOTE: default assignment first so no path leaves merged unassigned (no latch).
    merged = old_data;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/edge_detection_axil_regs.sv
// AXI4-Lite slave holding four 32-bit config registers for the edge-detection core,
// with independent write/read FSMs and a one-cycle per-register write strobe.
module edge_detection_axil_regs
  import edge_detection_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_aresetn,
  edge_detection_axil_regs_if.slave     s00_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
  output logic [3:0]                    reg_wr_o
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  w_state_t                      w_state;
  logic                          aw_held;
  logic                          w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]             wstrb_q;
  logic                          awready_q;
  logic                          wready_q;
  logic                          bvalid_q;

  r_state_t                      r_state;
  logic                          arready_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic                          aw_hs;
  logic                          w_hs;
  logic                          aw_now;
  logic                          w_now;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_now;
  logic [C_S_AXI_DATA_WIDTH-1:0] merged;

  // AW and W are accepted independently; "now" folds in a handshake happening this cycle.
  assign aw_hs      = s00_axi.awvalid && awready_q;
  assign w_hs       = s00_axi.wvalid && wready_q;
  assign aw_now     = aw_held || aw_hs;
  assign w_now      = w_held || w_hs;
  assign awaddr_now = aw_hs ? s00_axi.awaddr : awaddr_q;

  edge_detection_axil_wstrb_merge #(
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
  ) u_wstrb_merge (
    .old_data (regs[awaddr_q[3:2]]),
    .new_data (wdata_q),
    .strb     (wstrb_q),
    .merged   (merged)
  );

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      reg_wr_o  <= '0;
      // NOTE: only four words of flops, not a RAM, so the whole file is reset to a known config.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees this cycle's pre-edge state.
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_q <= s00_axi.awaddr;
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= s00_axi.wdata;
            wstrb_q <= s00_axi.wstrb;
          end
          if (aw_now && w_now) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            reg_wr_o  <= reg_onehot(awaddr_now[3:2]);
            w_state   <= W_COMMIT;
          end else begin
            awready_q <= !aw_now;
            wready_q  <= !w_now;
          end
        end
        W_COMMIT: begin
          regs[awaddr_q[3:2]] <= merged;
          reg_wr_o            <= '0;
          bvalid_q            <= 1'b1;
          aw_held             <= 1'b0;
          w_held              <= 1'b0;
          w_state             <= W_RESP;
        end
        W_RESP: begin
          if (s00_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // A read sampling regs in a commit cycle sees the pre-write value by construction.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s00_axi.arvalid && arready_q) begin
            rdata_q   <= regs[s00_axi.araddr[3:2]];
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = AXI_RESP_OKAY;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = AXI_RESP_OKAY;

  assign reg0_o = regs[REG_CTRL];
  assign reg1_o = regs[REG_THRESH];
  assign reg2_o = regs[REG_WIDTH];
  assign reg3_o = regs[REG_HEIGHT];

  // Protection bits and byte offsets carry no meaning for this register file.
  logic unused_bits;
  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, awaddr_q[1:0], s00_axi.araddr[1:0]};

endmodule

// File: tb/tb_edge_detection_axil_regs.sv
// Self-checking bench: shadow register model feeds read/write-strobe scoreboards.
module tb_edge_detection_axil_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] r0, r1, r2, r3;
  logic [3:0]  reg_wr;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          last_commit_cyc = 0;
  int          wr_pulses [4];
  logic [31:0] shadow [4];
  logic [31:0] rd_q [$];
  logic [3:0]  wr_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  edge_detection_axil_regs_if bus ();

  edge_detection_axil_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (bus),
    .reg0_o          (r0),
    .reg1_o          (r1),
    .reg2_o          (r2),
    .reg3_o          (r3),
    .reg_wr_o        (reg_wr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
    return m;
  endfunction

  function automatic logic [31:0] reg_out(input logic [1:0] i);
    case (i)
      2'd0:    return r0;
      2'd1:    return r1;
      2'd2:    return r2;
      default: return r3;
    endcase
  endfunction

  // Scoreboard side: write strobes and read data are popped as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr != 4'd0) begin
        last_commit_cyc = cyc;
        for (int i = 0; i < 4; i++) if (reg_wr[i]) wr_pulses[i]++;
        if (wr_q.size() == 0) check("unexpected_reg_wr", {28'd0, reg_wr}, 32'd0);
        else check("reg_wr", {28'd0, reg_wr}, {28'd0, wr_q.pop_front()});
      end
      if (bus.rvalid && bus.rready) begin
        check("rresp", {30'd0, bus.rresp}, 32'd0);
        if (rd_q.size() == 0) check("unexpected_rdata", 32'd1, 32'd0);
        else check("rdata", bus.rdata, rd_q.pop_front());
      end
    end
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0]  idx;
    logic [31:0] exp_val;
    bit          ok;
    idx     = addr[3:2];
    exp_val = tb_merge(shadow[idx], data, strb);
    wr_q.push_back(4'b0001 << idx);
    fork
      begin
        bit ok_aw;
        repeat (aw_dly) begin @(posedge clk); #1; end
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        ok_aw = 1'b0;
        for (int i = 0; i < 100 && !ok_aw; i++) begin @(negedge clk); ok_aw = bus.awready; end
        if (!ok_aw) check("aw_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
      end
      begin
        bit ok_w;
        repeat (w_dly) begin @(posedge clk); #1; end
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        ok_w = 1'b0;
        for (int i = 0; i < 100 && !ok_w; i++) begin @(negedge clk); ok_w = bus.wready; end
        if (!ok_w) check("w_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
      end
    join
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = bus.bvalid; end
    if (!ok) begin
      check("b_timeout", 32'd0, 32'd1);
    end else begin
      check("b_after_commit", cyc - last_commit_cyc, 32'd1);
      check("bresp", {30'd0, bus.bresp}, 32'd0);
      check("reg_out", reg_out(idx), exp_val);
      repeat (b_dly) begin
        @(negedge clk);
        check("b_hold_bvalid", {31'd0, bus.bvalid}, 32'd1);
        check("b_hold_readies", {30'd0, bus.awready, bus.wready}, 32'd0);
      end
      @(posedge clk); #1;
      bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
    end
    shadow[idx] = exp_val;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int ar_dly, input int r_dly);
    bit ok;
    repeat (ar_dly) begin @(posedge clk); #1; end
    rd_q.push_back(shadow[addr[3:2]]);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = bus.arready; end
    if (!ok) check("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", {31'd0, bus.rvalid}, 32'd1);
    ok = bus.rvalid;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = bus.rvalid; end
    if (!ok) check("r_timeout", 32'd0, 32'd1);
    repeat (r_dly) begin
      @(negedge clk);
      check("r_hold_rvalid", {31'd0, bus.rvalid}, 32'd1);
    end
    @(posedge clk); #1;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p1;
    rst_n       = 1'b0;
    bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    for (int i = 0; i < 4; i++) begin shadow[i] = '0; wr_pulses[i] = 0; end

    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, bus.awready}, 32'd0);
    check("rst_wready",  {31'd0, bus.wready},  32'd0);
    check("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    check("rst_arready", {31'd0, bus.arready}, 32'd0);
    check("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    check("rst_rdata",   bus.rdata, 32'd0);
    check("rst_reg_wr",  {28'd0, reg_wr}, 32'd0);
    check("rst_reg0",    r0, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 0, 0);
    check("reg3_o", r3, 32'h4);

    axi_write(4'h4, 32'h11223344, 4'hF, 0, 0, 0);
    p1 = wr_pulses[1];
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    check("wr_pulse_once", wr_pulses[1] - p1, 32'd1);
    axi_read(4'h4, 0, 2);

    axi_write(4'h8, 32'h00000055, 4'hF, 0, 3, 0);
    axi_write(4'hC, 32'h00000066, 4'hF, 3, 0, 0);
    axi_read(4'h8, 0, 0);
    axi_read(4'hC, 0, 0);

    axi_write(4'h0, 32'h00000077, 4'hF, 0, 0, 5);
    axi_write(4'h4, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    axi_read(4'h0, 0, 0);
    axi_read(4'h4, 0, 0);

    axi_write(4'h8, 32'h5, 4'hF, 0, 0, 0);
    fork
      axi_write(4'h8, 32'h9, 4'hF, 0, 0, 0);
      axi_read(4'h8, 1, 0);
    join
    axi_read(4'h8, 0, 0);

    axi_write(4'h3, 32'hCAFE0000, 4'b1100, 0, 0, 0);
    axi_read(4'h2, 0, 0);
    axi_read(4'hB, 0, 0);

    // Park both FSMs mid-transaction, then pull reset.
    wr_q.push_back(4'b0001);
    bus.awaddr = 4'h0; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    bus.araddr = 4'h4;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_bvalid", {31'd0, bus.bvalid}, 32'd1);
    check("pre_rst_rvalid", {31'd0, bus.rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("mid_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("mid_rst_regs",   r0 | r1 | r2 | r3, 32'd0);
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axi_read(4'h8, 0, 0);
    axi_write(4'hC, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(4'hC, 0, 0);

    repeat (3) @(posedge clk);
    check("rd_q_drained", rd_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
